voicemail_controller: RTL and testbench

Voicemail engine on the far side of the user interface's voicemail link. It accepts `voicemail_command` strobes from the UI, records 16-bit audio samples into fixed message slots in sample memory, and plays stored messages back. It reports its state to the UI on `voicemail_status`. It sits between the UI, the audio codec sample path and the CF/sample-memory writer.

---
 rtl/voicemail_controller.sv | 231 +++++++++++++++++++++++
 tb/tb_voicemail_controller.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voicemail_controller.sv
// Voicemail engine: records codec samples into fixed sample-memory slots and plays them
// back under command from the UI voicemail link.
module voicemail_controller #(
    parameter int unsigned MAX_MSGS  = 8,
    parameter int unsigned SLOT_BITS = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cf_present,
    input  logic [2:0]           voicemail_command,
    input  logic                 cmd_valid,
    input  logic [2:0]           sel_msg,
    input  logic                 ready,
    input  logic [15:0]          audio_in_data,
    output logic [15:0]          audio_out_data,
    output logic [SLOT_BITS+2:0] mem_addr,
    output logic [15:0]          mem_din,
    output logic                 mem_we,
    input  logic [15:0]          mem_dout,
    output logic [3:0]           voicemail_status,
    output logic [3:0]           msg_count,
    output logic                 cmd_err
);
    localparam int unsigned LenW = SLOT_BITS + 1;

    localparam logic [2:0] CmdNop     = 3'd0;
    localparam logic [2:0] CmdEnable  = 3'd1;
    localparam logic [2:0] CmdDisable = 3'd2;
    localparam logic [2:0] CmdRecord  = 3'd3;
    localparam logic [2:0] CmdStop    = 3'd4;
    localparam logic [2:0] CmdPlay    = 3'd5;
    localparam logic [2:0] CmdDelete  = 3'd6;

    typedef enum logic [2:0] {StNoCard, StDisabled, StIdle, StRecord, StPlay} state_e;

    state_e              state_q, state_d;
    logic                cf_meta_q, cf_sync_q;
    logic [7:0]          valid_q, valid_d;
    logic [LenW-1:0]     len_q [8];
    logic [LenW-1:0]     len_d [8];
    logic [2:0]          slot_q, slot_d;
    logic [LenW-1:0]     ptr_q, ptr_d;
    logic                mem_we_q, mem_we_d;
    logic [SLOT_BITS+2:0] mem_addr_q, mem_addr_d;
    logic [15:0]         mem_din_q, mem_din_d;
    logic [15:0]         audio_q, audio_d;
    logic                cmd_err_q, cmd_err_d;
    logic [1:0]          rd_pend_q, rd_pend_d;
    logic [1:0]          rd_last_q, rd_last_d;
    logic                play_done_q, play_done_d;

    logic [3:0]          count;
    logic [2:0]          free_slot;
    logic                full, stop, cmd_live;
    logic [SLOT_BITS+2:0] slot_addr;
    logic [LenW-1:0]     cur_len;

    // Occupancy and lowest-index free slot; scanning downwards leaves the lowest index last.
    always_comb begin
        count     = '0;
        free_slot = '0;
        for (int i = MAX_MSGS - 1; i >= 0; i--) begin
            count = count + 4'(valid_q[i]);
            if (!valid_q[i]) free_slot = 3'(i);
        end
    end

    assign full      = (count == 4'(MAX_MSGS));
    assign stop      = cmd_valid && (voicemail_command == CmdStop);
    assign cmd_live  = cmd_valid && (voicemail_command != CmdNop);
    assign slot_addr = {slot_q, ptr_q[SLOT_BITS-1:0]};
    assign cur_len   = len_q[slot_q];

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        len_d       = len_q;
        slot_d      = slot_q;
        ptr_d       = ptr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        audio_d     = audio_q;
        cmd_err_d   = 1'b0;
        rd_pend_d   = {rd_pend_q[0], 1'b0};
        rd_last_d   = {rd_last_q[0], 1'b0};
        play_done_d = play_done_q;

        if (!cf_sync_q) begin
            state_d = StNoCard;
            valid_d = '0;
        end else begin
            unique case (state_q)
                StNoCard: state_d = StDisabled;
                StDisabled: begin
                    if (cmd_live) begin
                        if (voicemail_command == CmdEnable) state_d = StIdle;
                        else cmd_err_d = 1'b1;
                    end
                end
                StIdle: begin
                    if (cmd_valid) begin
                        case (voicemail_command)
                            CmdNop, CmdStop: ;
                            CmdDisable: state_d = StDisabled;
                            CmdRecord: begin
                                if (full) begin
                                    cmd_err_d = 1'b1;
                                end else begin
                                    state_d = StRecord;
                                    slot_d  = free_slot;
                                    ptr_d   = '0;
                                end
                            end
                            CmdPlay: begin
                                if (valid_q[sel_msg]) begin
                                    state_d = StPlay;
                                    slot_d  = sel_msg;
                                    ptr_d   = '0;
                                end else begin
                                    cmd_err_d = 1'b1;
                                end
                            end
                            CmdDelete: begin
                                if (valid_q[sel_msg]) valid_d[sel_msg] = 1'b0;
                                else cmd_err_d = 1'b1;
                            end
                            default: cmd_err_d = 1'b1;
                        endcase
                    end
                end
                StRecord: begin
                    if (cmd_live && !stop) cmd_err_d = 1'b1;
                    if (stop) begin
                        state_d         = StIdle;
                        len_d[slot_q]   = ptr_q;
                        valid_d[slot_q] = (ptr_q != '0);
                    end else if (ready) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = slot_addr;
                        mem_din_d  = audio_in_data;
                        ptr_d      = ptr_q + LenW'(1);
                        // Last word of the slot: close the message at full length.
                        if (&ptr_q[SLOT_BITS-1:0]) begin
                            state_d         = StIdle;
                            len_d[slot_q]   = ptr_q + LenW'(1);
                            valid_d[slot_q] = 1'b1;
                        end
                    end
                end
                StPlay: begin
                    if (cmd_live && !stop) cmd_err_d = 1'b1;
                    if (stop || play_done_q) begin
                        state_d = StIdle;
                    end else if (ready && (ptr_q < cur_len)) begin
                        mem_addr_d   = slot_addr;
                        ptr_d        = ptr_q + LenW'(1);
                        rd_pend_d[0] = 1'b1;
                        rd_last_d[0] = ((ptr_q + LenW'(1)) == cur_len);
                    end
                end
                default: state_d = StNoCard;
            endcase
        end

        // Two-stage read pipeline: address out, then memory data captured to the codec.
        if (state_d != StPlay) begin
            rd_pend_d   = '0;
            rd_last_d   = '0;
            play_done_d = 1'b0;
            audio_d     = '0;
        end else if (rd_pend_q[1]) begin
            audio_d = mem_dout;
            if (rd_last_q[1]) play_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cf_meta_q   <= 1'b0;
            cf_sync_q   <= 1'b0;
            state_q     <= StNoCard;
            valid_q     <= '0;
            for (int i = 0; i < 8; i++) len_q[i] <= '0;
            slot_q      <= '0;
            ptr_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            audio_q     <= '0;
            cmd_err_q   <= 1'b0;
            rd_pend_q   <= '0;
            rd_last_q   <= '0;
            play_done_q <= 1'b0;
        end else begin
            cf_meta_q   <= cf_present;
            cf_sync_q   <= cf_meta_q;
            state_q     <= state_d;
            valid_q     <= valid_d;
            len_q       <= len_d;
            slot_q      <= slot_d;
            ptr_q       <= ptr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            audio_q     <= audio_d;
            cmd_err_q   <= cmd_err_d;
            rd_pend_q   <= rd_pend_d;
            rd_last_q   <= rd_last_d;
            play_done_q <= play_done_d;
        end
    end

    always_comb begin
        unique case (state_q)
            StNoCard:   voicemail_status = 4'd0;
            StDisabled: voicemail_status = 4'd1;
            StIdle:     voicemail_status = full ? 4'd5 : 4'd2;
            StRecord:   voicemail_status = 4'd3;
            StPlay:     voicemail_status = 4'd4;
            default:    voicemail_status = 4'd0;
        endcase
    end

    assign msg_count      = count;
    assign audio_out_data = audio_q;
    assign mem_addr       = mem_addr_q;
    assign mem_din        = mem_din_q;
    assign mem_we         = mem_we_q;
    assign cmd_err        = cmd_err_q;
endmodule

// File: tb/tb_voicemail_controller.sv
// Bench for voicemail_controller: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a transaction-level model.
module tb_voicemail_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic        cf_present, cmd_valid, ready;
    logic [2:0]  voicemail_command, sel_msg;
    logic [15:0] audio_in_data, mem_dout, audio_out_data, mem_din;
    logic [14:0] mem_addr;
    logic        mem_we, cmd_err;
    logic [3:0]  voicemail_status, msg_count;

    logic        s_cf, s_cmd_valid, s_ready, s_we, s_err;
    logic [2:0]  s_cmd, s_sel;
    logic [15:0] s_din, s_dout, s_aud, s_wdata;
    logic [4:0]  s_addr;
    logic [3:0]  s_status, s_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    voicemail_controller dut (
        .clk(clk), .reset(reset), .cf_present(cf_present),
        .voicemail_command(voicemail_command), .cmd_valid(cmd_valid), .sel_msg(sel_msg),
        .ready(ready), .audio_in_data(audio_in_data), .audio_out_data(audio_out_data),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
        .voicemail_status(voicemail_status), .msg_count(msg_count), .cmd_err(cmd_err)
    );

    voicemail_controller #(.MAX_MSGS(8), .SLOT_BITS(2)) dut_small (
        .clk(clk), .reset(reset), .cf_present(s_cf),
        .voicemail_command(s_cmd), .cmd_valid(s_cmd_valid), .sel_msg(s_sel),
        .ready(s_ready), .audio_in_data(s_din), .audio_out_data(s_aud),
        .mem_addr(s_addr), .mem_din(s_wdata), .mem_we(s_we), .mem_dout(s_dout),
        .voicemail_status(s_status), .msg_count(s_count), .cmd_err(s_err)
    );

    assign s_dout = 16'h0000;

    // Sample memory with one-cycle read latency.
    logic [15:0] ram [0:32767];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    // ---------------- behavioural model ----------------
    typedef struct packed { int due; logic [15:0] data; logic last; } rd_t;
    rd_t         m_q[$];
    int          m_mode, m_slot, m_ptr, m_edge, m_fin;
    bit          m_valid [8];
    int          m_len [8];
    logic [15:0] m_mem [0:32767];
    bit          m_h1, m_h2;
    int          e_addr;
    logic [15:0] e_din, e_aud;
    bit          e_we, e_err;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    function automatic int m_status();
        return (m_mode == 2 && m_count() == 8) ? 5 : m_mode;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_slot = 0; m_ptr = 0; m_fin = -1;
        for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_len[i] = 0; end
        m_q.delete();
        m_h1 = 0; m_h2 = 0;
        e_addr = 0; e_din = 0; e_aud = 0; e_we = 0; e_err = 0;
    endtask

    task automatic model_step();
        bit seen;
        int c;
        bit stp;
        m_edge++;
        e_we = 0; e_err = 0;
        seen = m_h2; m_h2 = m_h1; m_h1 = cf_present;
        c = cmd_valid ? int'(voicemail_command) : 0;
        stp = (c == 4);
        if (!seen) begin
            m_mode = 0; m_q.delete(); m_fin = -1; e_aud = 0;
            for (int i = 0; i < 8; i++) m_valid[i] = 0;
        end else begin
            case (m_mode)
                0: m_mode = 1;
                1: if (c == 1) m_mode = 2; else if (c != 0) e_err = 1;
                2: begin
                    if (c == 2) m_mode = 1;
                    else if (c == 3) begin
                        if (m_count() == 8) e_err = 1;
                        else begin
                            m_slot = 0;
                            while (m_valid[m_slot]) m_slot++;
                            m_ptr = 0; m_mode = 3;
                        end
                    end else if (c == 5) begin
                        if (m_valid[sel_msg]) begin
                            m_slot = int'(sel_msg); m_ptr = 0; m_mode = 4; m_fin = -1;
                        end else e_err = 1;
                    end else if (c == 6) begin
                        if (m_valid[sel_msg]) m_valid[sel_msg] = 0; else e_err = 1;
                    end else if (c == 1 || c == 7) e_err = 1;
                end
                3: begin
                    if (c != 0 && !stp) e_err = 1;
                    if (!stp && ready) begin
                        e_we = 1; e_addr = m_slot * 4096 + m_ptr; e_din = audio_in_data;
                        m_mem[e_addr] = audio_in_data;
                        m_ptr++;
                    end
                    if (stp || m_ptr == 4096) begin
                        m_len[m_slot] = m_ptr; m_valid[m_slot] = (m_ptr > 0); m_mode = 2;
                    end
                end
                4: begin
                    if (c != 0 && !stp) e_err = 1;
                    if (stp || m_fin == m_edge) begin
                        m_mode = 2; e_aud = 0; m_q.delete(); m_fin = -1;
                    end else begin
                        if (m_q.size() > 0 && m_q[0].due == m_edge) begin
                            e_aud = m_q[0].data;
                            if (m_q[0].last) m_fin = m_edge + 1;
                            void'(m_q.pop_front());
                        end
                        if (ready && m_ptr < m_len[m_slot]) begin
                            e_addr = m_slot * 4096 + m_ptr;
                            m_q.push_back('{m_edge + 2, m_mem[e_addr], m_ptr == m_len[m_slot] - 1});
                            m_ptr++;
                        end
                    end
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic compare();
        chk("status", int'(voicemail_status), m_status());
        chk("msg_count", int'(msg_count), m_count());
        chk("cmd_err", int'(cmd_err), int'(e_err));
        chk("mem_we", int'(mem_we), int'(e_we));
        chk("mem_addr", int'(mem_addr), e_addr);
        chk("mem_din", int'(mem_din), int'(e_din));
        chk("audio_out", int'(audio_out_data), int'(e_aud));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset(); else model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic send(input logic [2:0] c, input logic [2:0] s);
        cmd_valid = 1; voicemail_command = c; sel_msg = s;
        tick();
        cmd_valid = 0; voicemail_command = 0;
    endtask

    task automatic pulse(input logic [15:0] d);
        ready = 1; audio_in_data = d;
        tick();
        ready = 0;
    endtask

    task automatic s_send(input logic [2:0] c);
        s_cmd_valid = 1; s_cmd = c;
        tick();
        s_cmd_valid = 0; s_cmd = 0;
    endtask

    logic [2:0] cmd_tab [12] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5,
                                 3'd6, 3'd7};
    int cf_off;

    initial begin
        reset = 1; cf_present = 0; cmd_valid = 0; voicemail_command = 0; sel_msg = 0;
        ready = 0; audio_in_data = 0;
        s_cf = 0; s_cmd_valid = 0; s_cmd = 0; s_sel = 0; s_ready = 0; s_din = 0;
        m_edge = 0; cf_off = 0;
        model_reset();
        #1;
        chk("rst_status", int'(voicemail_status), 0);
        chk("rst_count", int'(msg_count), 0);
        chk("rst_we_err", int'({mem_we, cmd_err}), 0);
        chk("rst_addr_din_aud", int'(mem_addr) + int'(mem_din) + int'(audio_out_data), 0);
        @(negedge clk);
        tick();
        reset = 0;

        // Small slots: the fourth write fills the slot and closes the message.
        s_cf = 1;
        tick(); tick();
        tick();
        chk("small_status_disabled", int'(s_status), 1);
        s_send(3'd1);
        s_send(3'd3);
        chk("small_status_rec", int'(s_status), 3);
        for (int i = 0; i < 4; i++) begin
            s_ready = 1; s_din = 16'(16'hA0 + i);
            tick();
            s_ready = 0;
            chk("small_we", int'(s_we), 1);
            chk("small_addr", int'(s_addr), i);
            chk("small_wdata", int'(s_wdata), 16'hA0 + i);
        end
        chk("small_auto_stop", int'(s_status), 2);
        chk("small_count", int'(s_count), 1);
        s_ready = 1; tick(); s_ready = 0;
        chk("small_no_write_after_stop", int'(s_we), 0);
        chk("small_err_aud", int'(s_err) + int'(s_aud), 0);

        // Card insert and enable.
        cf_present = 1;
        tick(); tick();
        chk("card_sync_delay", int'(voicemail_status), 0);
        tick();
        chk("card_status", int'(voicemail_status), 1);
        send(3'd1, 0);
        chk("enable_status", int'(voicemail_status), 2);
        chk("enable_err", int'(cmd_err), 0);

        // Five-sample message into slot 0.
        send(3'd3, 0);
        chk("rec_status", int'(voicemail_status), 3);
        for (int i = 0; i < 5; i++) begin
            pulse(16'(16'h1000 + i));
            chk("rec_we", int'(mem_we), 1);
            chk("rec_addr", int'(mem_addr), i);
            chk("rec_din", int'(mem_din), 16'h1000 + i);
        end
        send(3'd4, 0);
        chk("rec_done_status", int'(voicemail_status), 2);
        chk("rec_done_count", int'(msg_count), 1);

        // Playback of slot 0.
        send(3'd5, 0);
        chk("play_status", int'(voicemail_status), 4);
        for (int i = 0; i < 5; i++) begin
            pulse(16'h0);
            chk("play_addr", int'(mem_addr), i);
            tick(); tick();
            chk("play_audio", int'(audio_out_data), 16'h1000 + i);
        end
        tick();
        chk("play_end_status", int'(voicemail_status), 2);
        chk("play_end_audio", int'(audio_out_data), 0);

        // Fill all slots, then error/reuse cases.
        for (int k = 1; k < 8; k++) begin
            send(3'd3, 0); pulse(16'(16'h2000 + k)); send(3'd4, 0);
        end
        chk("full_count", int'(msg_count), 8);
        chk("full_status", int'(voicemail_status), 5);
        send(3'd3, 0);
        chk("full_rec_err", int'(cmd_err), 1);
        chk("full_rec_status", int'(voicemail_status), 5);
        send(3'd6, 3);
        chk("delete_count", int'(msg_count), 7);
        send(3'd3, 0);
        pulse(16'h3333);
        chk("reuse_addr", int'(mem_addr), 15'h3000);
        chk("reuse_we", int'(mem_we), 1);
        send(3'd4, 0);
        send(3'd6, 5);
        send(3'd5, 5);
        chk("play_empty_err", int'(cmd_err), 1);

        // STOP together with ready: no write, zero-length slot stays free.
        send(3'd3, 0);
        cmd_valid = 1; voicemail_command = 3'd4; ready = 1;
        tick();
        cmd_valid = 0; voicemail_command = 0; ready = 0;
        chk("stop_ready_we", int'(mem_we), 0);
        chk("stop_ready_count", int'(msg_count), 7);

        // Card removed mid-record.
        send(3'd3, 0);
        pulse(16'h0001);
        cf_present = 0; ready = 1;
        tick(); tick(); tick();
        chk("remove_status", int'(voicemail_status), 0);
        chk("remove_count", int'(msg_count), 0);
        chk("remove_we", int'(mem_we), 0);
        tick();
        ready = 0;
        chk("remove_we_stays", int'(mem_we), 0);

        // Reinsert, record, and reset during playback.
        cf_present = 1;
        tick(); tick(); tick();
        send(3'd1, 0);
        send(3'd3, 0);
        for (int i = 0; i < 3; i++) pulse(16'(16'h5000 + i));
        send(3'd4, 0);
        send(3'd5, 0);
        pulse(16'h0);
        tick(); tick();
        chk("pre_reset_audio", int'(audio_out_data), 16'h5000);
        reset = 1;
        model_reset();
        #1;
        chk("mid_play_reset_status", int'(voicemail_status), 0);
        chk("mid_play_reset_audio", int'(audio_out_data), 0);
        chk("mid_play_reset_mem", int'(mem_addr) + int'(mem_din) + int'(mem_we), 0);
        chk("mid_play_reset_cnt_err", int'(msg_count) + int'(cmd_err), 0);
        tick();
        reset = 0;

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            if (cf_off > 0) begin
                cf_off--;
                cf_present = (cf_off == 0);
            end else if ($urandom_range(0, 799) == 0) begin
                cf_off = $urandom_range(1, 6);
                cf_present = 0;
            end
            cmd_valid = ($urandom_range(0, 4) == 0);
            voicemail_command = cmd_valid ? cmd_tab[$urandom_range(0, 11)] : 3'd0;
            sel_msg = 3'($urandom_range(0, 7));
            ready = ($urandom_range(0, 2) == 0);
            audio_in_data = 16'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
